// File: rtl/muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared CPU decode definitions for the RV32M extension.
//   - funct3 encodings of the eight M-extension operations
//   - funct7 value that routes an R-type instruction to the mul/div unit
//   - decode helpers shared by the ALU control and muldiv_unit
// No ports (package).
// ----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // R-type instruction that belongs to the M extension.
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

    // Divide/remainder class: funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    // Operand A (multiplicand/dividend) is interpreted as signed.
    function automatic logic a_is_signed(input logic [2:0] funct3);
        return funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    // Operand B (multiplier/divisor) is interpreted as signed.
    function automatic logic b_is_signed(input logic [2:0] funct3);
        return funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// engine, one bit per cycle, serving all eight M-extension operations.
//
// Ports:
//   i_clk        system clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      request, accepted only in IDLE and when i_flush is low
//   i_funct3     operation (MUL..REMU)
//   i_rs1_data   operand A (multiplicand / dividend)
//   i_rs2_data   operand B (multiplier / divisor)
//   i_flush      aborts any operation; returns to IDLE without o_done
//   o_busy       stall request: accept cycle (combinational) and all of CALC
//   o_done       one-cycle pulse, o_result valid
//   o_result     result, held from o_done until the next completed operation
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: the EX stage raises i_start with operands valid; o_busy rises in
// that same cycle and stays high until the result is ready. o_done pulses for
// exactly one cycle with o_result valid; o_busy is low in that cycle so the
// stage advances with the result. i_start outside IDLE is dropped, not queued.
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [1:0]            o_dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     f3_q, f3_d;
    logic           sa_q, sa_d;       // operand A was negative (signed op)
    logic           sb_q, sb_d;       // operand B was negative (signed op)
    logic           fast_q, fast_d;   // lo_q already holds the final result
    // Engine registers. Multiply: {hi,lo} is the 64-bit product register with
    // the multiplier shifting out of lo. Divide: hi is the remainder, lo the
    // quotient (dividend bits shift out the top as quotient bits shift in).
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
    logic [W-1:0]   result_q, result_d;

    // Capture-side decode
    logic           a_neg, b_neg, cap_div, div_zero, div_ovf, cap_fast;
    logic [W-1:0]   a_mag, b_mag, fast_val;

    // Iteration datapath
    logic [W:0]     add_sum;
    logic [W:0]     shifted;
    logic           sub_ok;
    logic [W-1:0]   diff;

    // Completion datapath
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   q_fix, r_fix, final_res;

    always_comb begin
        a_neg    = a_is_signed(i_funct3) & i_rs1_data[W-1];
        b_neg    = b_is_signed(i_funct3) & i_rs2_data[W-1];
        a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
        b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
        cap_div  = is_div_op(i_funct3);
        div_zero = cap_div && (i_rs2_data == '0);
        // Only DIV/REM (funct3[0]==0) can overflow.
        div_ovf  = cap_div && !i_funct3[0] && (i_rs1_data == MIN_NEG) && (i_rs2_data == '1);
        cap_fast = div_zero | div_ovf;
        // funct3[1] distinguishes remainder from quotient in the divide class.
        if (div_zero) begin
            fast_val = i_funct3[1] ? i_rs1_data : '1;
        end else begin
            fast_val = i_funct3[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[W-1]};
        sub_ok  = (shifted >= {1'b0, b_q});
        // When sub_ok, the true difference is below the divisor, so the low
        // W bits of the modular subtraction are exact.
        diff    = shifted[W-1:0] - b_q;
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        q_fix    = (sa_q ^ sb_q) ? -lo_q : lo_q;
        r_fix    = sa_q ? -hi_q : hi_q;
        if (fast_q) begin
            final_res = lo_q;
        end else begin
            case (f3_q)
                F3_MUL:                      final_res = prod_fix[W-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*W-1:W];
                F3_DIV, F3_DIVU:             final_res = q_fix;
                default:                     final_res = r_fix;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        fast_d   = fast_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_result = result_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_flush) begin
                    o_busy  = 1'b1;
                    f3_d    = i_funct3;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    fast_d  = cap_fast;
                    hi_d    = '0;
                    cnt_d   = '1;
                    if (cap_fast) begin
                        lo_d    = fast_val;
                        b_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = cap_div ? a_mag : b_mag;
                        b_d     = cap_div ? b_mag : a_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (f3_q[2]) begin
                    hi_d = sub_ok ? diff : shifted[W-1:0];
                    lo_d = {lo_q[W-2:0], sub_ok};
                end else begin
                    {hi_d, lo_d} = {add_sum, lo_q[W-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (!i_flush) begin
                    o_done   = 1'b1;
                    o_result = final_res;
                    result_d = final_res;
                end
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            fast_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            fast_q   <= fast_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Inputs change on the falling edge,
// outputs are sampled 1 ns after it. Expected results come from a reference
// model written with plain 64-bit / signed integer arithmetic.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = '0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_funct3    (f3),
        .i_rs1_data  (a),
        .i_rs2_data  (b),
        .i_flush     (flush),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'h0, y});
        case (op)
            OP_MUL:    begin p = sx * sy; return p[31:0]; end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            OP_DIV: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(x) / $signed(y);
            end
            OP_DIVU:   return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            OP_REM: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default:   return (y == 32'h0) ? x : x % y;
        endcase
    endfunction

    // Latency rule: divide by zero and signed overflow finish in one cycle.
    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2] && y == 32'h0) return 1;
        if ((op == OP_DIV || op == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one start and follows it until o_done (bounded). lat = cycles
    // from the accept edge to the o_done cycle, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int busy_cnt,
                          output logic busy_in_done);
        @(negedge clk);
        start = 1'b1; f3 = op; a = x; b = y;
        #1;
        busy_cnt     = busy ? 1 : 0;
        lat          = -1;
        res          = 'x;
        busy_in_done = 1'b1;
        @(negedge clk);
        start = 1'b0; f3 = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        for (int c = 1; c <= 64; c++) begin
            #1;
            if (done) begin
                lat          = c;
                res          = result;
                busy_in_done = busy;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst = 1'b0;
        last_result = '0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[13];
        logic [31:0] res;
        int          lat, bcnt;
        logic        bdone;
        v[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        v[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        v[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        v[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        v[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        v[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        v[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
        v[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         33};
        v[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        v[9]  = '{OP_REMU,   32'd5,         32'd0,         32'd5,         1};
        v[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        v[12] = '{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].x, v[i].y, res, lat, bcnt, bdone);
            checks++;
            if (res !== v[i].e) begin
                failures++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, res, v[i].e);
            end
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
            checks++;
            if (bcnt !== v[i].lat || bdone !== 1'b0) begin
                failures++;
                $display("FAIL directed_busy[%0d]: cycles %0d in_done %b expected %0d 0", i, bcnt, bdone, v[i].lat);
            end
            // Result must be held and o_done must drop in the following cycle.
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || result !== v[i].e) begin
                failures++;
                $display("FAIL directed_hold[%0d]: done=%b result=%h expected 0 %h", i, done, result, v[i].e);
            end
            last_result = v[i].e;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] x, y, res, e;
        int          lat, bcnt, elat;
        logic        bdone;
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            x    = pick_operand();
            y    = pick_operand();
            elat = ref_latency(op, x, y);
            exp_q.push_back(ref_model(op, x, y));
            run_op(op, x, y, res, lat, bcnt, bdone);
            e = exp_q.pop_front();
            checks++;
            if (res !== e || lat !== elat) begin
                failures++;
                $display("FAIL random[%0d] op=%0d %h,%h: got %h lat %0d expected %h lat %0d",
                         i, op, x, y, res, lat, e, elat);
            end
            last_result = e;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] x, y, res, e;
        int          lat, bcnt;
        logic        bdone;
        for (int i = 0; i < 4; i++) begin
            op = (i % 2 == 0) ? 3'($urandom_range(0, 3)) : OP_DIVU;
            x  = $urandom;
            y  = $urandom | 32'h1;
            exp_q.push_back(ref_model(op, x, y));
            run_op(op, x, y, res, lat, bcnt, bdone);
            e = exp_q.pop_front();
            checks++;
            if (res !== e || lat !== 33 || bcnt !== 33) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h lat %0d busy %0d expected %h 33 33", i, res, lat, bcnt, e);
            end
            last_result = e;
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, prev;
        int          lat, bcnt, dcnt;
        logic        bdone;
        prev = last_result;
        // Flush mid-calculation.
        @(negedge clk);
        start = 1'b1; f3 = OP_MULHU; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: busy=%b state=%0d done=%b expected 0 0 0", busy, dbg_state, done);
        end
        checks++;
        if (result !== prev) begin
            failures++;
            $display("FAIL flush_result_kept: got %h expected %h", result, prev);
        end
        run_op(OP_MUL, 32'd3, 32'd4, res, lat, bcnt, bdone);
        checks++;
        if (res !== 32'd12 || lat !== 33) begin
            failures++;
            $display("FAIL flush_next_op: got %h lat %0d expected 0000000c 33", res, lat);
        end
        last_result = 32'd12;
        // Flush together with a start in IDLE: flush wins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; f3 = OP_DIVU; a = 32'd9; b = 32'd0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) dcnt++;
            @(negedge clk);
        end
        checks++;
        if (dcnt !== 0 || result !== 32'd12) begin
            failures++;
            $display("FAIL flush_start_ignored: dones %0d result %h expected 0 0000000c", dcnt, result);
        end
    endtask

    task automatic test_start_ignored();
        logic [2:0]  op;
        logic [31:0] x, y, e, res;
        int          dcnt, lat;
        op = 3'($urandom_range(0, 3));
        x  = $urandom;
        y  = $urandom;
        exp_q.push_back(ref_model(op, x, y));
        @(negedge clk);
        start = 1'b1; f3 = op; a = x; b = y;
        @(negedge clk);
        dcnt = 0; lat = -1; res = 'x;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5 || c == 15 || c == 33);
            f3    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = 32'h0;
            #1;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = c; res = result; end
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (dcnt !== 1) begin
            failures++;
            $display("FAIL start_ignored_count: got %0d expected 1", dcnt);
        end
        checks++;
        if (res !== e || lat !== 33) begin
            failures++;
            $display("FAIL start_ignored_result: got %h lat %0d expected %h 33", res, lat, e);
        end
        last_result = e;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          dcnt, lat, bcnt;
        logic        bdone;
        @(negedge clk);
        start = 1'b1; f3 = OP_DIVU; a = $urandom; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h state=%0d expected 0 0 0 0",
                     busy, done, result, dbg_state);
        end
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d expected 0", dcnt);
        end
        run_op(OP_MULH, 32'hFFFF_FFFE, 32'h0000_0003, res, lat, bcnt, bdone);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 33) begin
            failures++;
            $display("FAIL reset_mid_recover: got %h lat %0d expected ffffffff 33", res, lat);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. When funct7 = 0000001 on an R-type instruction, the EX stage starts this unit instead of the ALU. The EX stage is held off through `o_busy`, and the 32-bit result is taken on `o_done`. A single shift-add/restoring-divide engine serves all eight M-extension operations at one bit per cycle.

## Interface
- `DATA_WIDTH`, 32: operand/result width; iteration count equals `DATA_WIDTH`.
- `i_clk`  in  1  system clock; one clock, all state on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  request; accepted only in IDLE.
- `i_funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_rs1_data`  in  DATA_WIDTH  operand A (multiplicand/dividend).
- `i_rs2_data`  in  DATA_WIDTH  operand B (multiplier/divisor).
- `i_flush`  in  1  pipeline flush; aborts any operation.
- `o_busy`  out  1  high in CALC and on the cycle a start is accepted; EX stall request.
- `o_done`  out  1  one-cycle pulse, result valid.
- `o_result`  out  DATA_WIDTH  result; held from `o_done` until the next accepted start.

## Operation
- States:
  - IDLE: start accepted, operands captured, funct3 latched.
  - CALC: 32 iterations, 5-bit counter 31→0.
  - DONE: final sign fix; `o_done`=1. Always returns to IDLE.
- Accept condition: IDLE & `i_start` & !`i_flush` → CALC. Fast-path cases go directly to DONE instead.
- Signedness on capture: operands are converted to magnitudes; the result sign is recorded.
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - Unsigned ops: no conversion.
- Multiply: 64-bit product register, shift-add one bit/cycle.
  - MUL returns the low word.
  - MULH/MULHSU/MULHU return the high word of the two's-complement-corrected product.
- Divide: restoring, 32-bit quotient and remainder registers.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
  - Quotient is negative when the operand signs differ; remainder takes the dividend's sign.
- Fast paths (skip CALC, DONE next cycle):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `i_start` while not IDLE: ignored, no queueing.

## Timing
- Start sampled at edge N.
- Normal op: CALC covers N+1..N+32, `o_done` is high in cycle N+33, `o_result` is valid in that same cycle. Latency 33 cycles.
- Fast path: `o_done` is high in cycle N+1.
- `o_busy`:
  - Combinationally high in the accept cycle, so the EX stage stalls immediately.
  - High through CALC.
  - Low in DONE, so the EX stage advances with the result.
- Back-to-back: a start is accepted again the cycle after DONE (IDLE).
- `i_flush`: any state → IDLE at the next edge; no `o_done`; `o_result` unchanged. In IDLE with simultaneous `i_start`, flush wins.
- Reset, including mid-CALC: IDLE, counter 0, `o_busy`=0, `o_done`=0, `o_result`=0.

## Structure
- Shared CPU package/header holds:
  - M-extension funct3 localparams (MUL…REMU).
  - MULDIV funct7 constant 7'b0000001.
  - The decode helper used by the ALU control and this unit.
- State encoding (IDLE/CALC/DONE) is local.
- No sub-module: the datapath is one shared shift/add-subtract engine, muxed by op class.

## Test plan
- MUL 7 × 0xFFFFFFFD → `o_result` 0xFFFFFFEB; `o_done` exactly 33 cycles after start; `o_busy` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. Each with `o_done` one cycle after start.
- Flush at start+10 → IDLE next cycle, no `o_done`; `o_result` keeps its old value; new MUL 3×4 accepted next cycle → 12.
- `i_rst` at start+20 → all outputs 0 next cycle. `i_start` pulses during CALC are ignored, so exactly one `o_done` per accepted start.
